accum_sequencer: RTL and testbench

//  Two-requester round-robin arbiter and sequencer for the 8-bit accumulate datapath (adder + sum register).

---
 rtl/accum_sequencer_if.sv | 25 ++
 rtl/accum_sequencer.sv | 100 ++++++++++
 tb/tb_accum_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_sequencer_if.sv
// Requester-side handshake bundle for accum_sequencer: two operand channels sharing one grant.
// master : requester side (drives valid/data, observes ready).
// slave  : sequencer side (observes valid/data, drives ready).
interface accum_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [1:0]       req_ready;

  modport master (
    output req_valid,
    output req_data0,
    output req_data1,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data0,
    input  req_data1,
    output req_ready
  );
endinterface

// File: rtl/accum_sequencer.sv
// Purpose: two-requester round-robin arbiter feeding an 8-bit accumulate datapath (acc + sticky carry + op count).
// Latency: operand accepted at edge E0, committed at E1 (PACED=0) or at the first step_en edge (PACED=1); done follows.
// Backpressure: at most one req_ready bit high, only in IDLE and never during clear; one operand in flight.
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   clear              synchronous clear of acc/overflow/op_count (highest priority, drops held operand)
//   step_en            commit strobe used when PACED=1
//   req                slave side of accum_sequencer_if (req_valid, req_data0/1, req_ready)
//   acc, overflow      accumulator and sticky carry-out
//   op_count           saturating committed-operation counter
//   last_src           requester index of the most recent commit
//   busy, done         operand held / one-cycle pulse after each commit
module accum_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int PACED = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             step_en,
  accum_sequencer_if.slave req,
  output logic [WIDTH-1:0] acc,
  output logic             overflow,
  output logic [CNT_W-1:0] op_count,
  output logic             last_src,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ADD  = 1'b1;

  logic [0:0]       state;
  logic             rr;        // requester to favour when both are valid
  logic [WIDTH-1:0] op;        // held operand
  logic             src;       // requester that supplied the held operand

  logic             gnt_any;
  logic             gnt_idx;
  logic             xfer;
  logic             commit;
  logic [WIDTH:0]   sum;

  // Combinational grant: a lone requester wins outright; on contention the rr pointer decides.
  always_comb begin
    gnt_any = |req.req_valid;
    gnt_idx = (req.req_valid == 2'b11) ? rr : req.req_valid[1];
    req.req_ready = 2'b00;
    if ((state == ST_IDLE) && !clear && gnt_any) begin
      req.req_ready = gnt_idx ? 2'b10 : 2'b01;
    end
  end

  assign xfer   = |(req.req_valid & req.req_ready);
  assign commit = (state == ST_ADD) && !clear && ((PACED == 0) || step_en);
  assign sum    = {1'b0, acc} + {1'b0, op};
  assign busy   = (state == ST_ADD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      rr       <= 1'b0;
      op       <= '0;
      src      <= 1'b0;
      acc      <= '0;
      overflow <= 1'b0;
      op_count <= '0;
      last_src <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        // last_src and rr deliberately survive a clear; a held operand is simply abandoned.
        state    <= ST_IDLE;
        acc      <= '0;
        overflow <= 1'b0;
        op_count <= '0;
      end else if (state == ST_IDLE) begin
        if (xfer) begin
          state <= ST_ADD;
          op    <= gnt_idx ? req.req_data1 : req.req_data0;
          src   <= gnt_idx;
          rr    <= ~gnt_idx;
        end
      end else if (commit) begin
        state    <= ST_IDLE;
        acc      <= sum[WIDTH-1:0];
        overflow <= overflow | sum[WIDTH];
        if (op_count != {CNT_W{1'b1}}) begin
          op_count <= op_count + 1'b1;
        end
        last_src <= src;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_accum_sequencer.sv
// Bench for accum_sequencer: one PACED=0 and one PACED=1 instance, exercised one at a time.
// A transaction-level model predicts each commit and pushes it to a scoreboard; a monitor pops on done.
`timescale 1ns/1ps
module tb_accum_sequencer;
  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       clear_i, step_i;
  logic [1:0] vld;
  logic [7:0] d0, d1;
  int         sel;  // which instance receives stimulus

  accum_sequencer_if #(.WIDTH(W)) if0 ();
  accum_sequencer_if #(.WIDTH(W)) if1 ();

  assign if0.req_valid = (sel == 0) ? vld : 2'b00;
  assign if0.req_data0 = d0;
  assign if0.req_data1 = d1;
  assign if1.req_valid = (sel == 1) ? vld : 2'b00;
  assign if1.req_data0 = d0;
  assign if1.req_data1 = d1;

  logic [W-1:0]  acc0, acc1;
  logic          ovf0, ovf1, src0, src1, busy0, busy1, done0, done1;
  logic [CW-1:0] cnt0, cnt1;

  accum_sequencer #(.WIDTH(W), .CNT_W(CW), .PACED(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .clear((sel == 0) && clear_i), .step_en((sel == 0) && step_i),
    .req(if0.slave), .acc(acc0), .overflow(ovf0), .op_count(cnt0), .last_src(src0),
    .busy(busy0), .done(done0)
  );

  accum_sequencer #(.WIDTH(W), .CNT_W(CW), .PACED(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .clear((sel == 1) && clear_i), .step_en((sel == 1) && step_i),
    .req(if1.slave), .acc(acc1), .overflow(ovf1), .op_count(cnt1), .last_src(src1),
    .busy(busy1), .done(done1)
  );

  // Outputs of the instance under test.
  logic [W-1:0]  o_acc;
  logic [CW-1:0] o_cnt;
  logic          o_ovf, o_src, o_busy, o_done;
  logic [1:0]    o_rdy;
  assign o_acc  = (sel == 1) ? acc1  : acc0;
  assign o_cnt  = (sel == 1) ? cnt1  : cnt0;
  assign o_ovf  = (sel == 1) ? ovf1  : ovf0;
  assign o_src  = (sel == 1) ? src1  : src0;
  assign o_busy = (sel == 1) ? busy1 : busy0;
  assign o_done = (sel == 1) ? done1 : done0;
  assign o_rdy  = (sel == 1) ? if1.req_ready : if0.req_ready;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: what the block holds, what it has accumulated, whom it granted last.
  int m_acc, m_ovf, m_cnt, m_lsrc, m_last, m_hold, m_op, m_src;

  task automatic model_reset();
    m_acc = 0; m_ovf = 0; m_cnt = 0; m_lsrc = 0;
    m_last = 1;  // nobody granted yet: requester 0 wins the first contention
    m_hold = 0; m_op = 0; m_src = 0;
  endtask

  typedef struct {
    int acc;
    int ovf;
    int cnt;
    int src;
    int at;
  } exp_t;
  exp_t sb[$];

  // Scoreboard monitor: every done pulse must match the oldest predicted commit, on the predicted cycle.
  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1 && o_done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", o_done, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("done_acc", o_acc, e.acc);
        chk("done_ovf", o_ovf, e.ovf);
        chk("done_cnt", o_cnt, e.cnt);
        chk("done_src", o_src, e.src);
      end
    end
  end

  // One clock cycle: apply inputs, check the instance against the model, then predict the coming edge.
  task automatic step_cycle(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                            input logic clr, input logic stp);
    logic [1:0] exp_rdy;
    int g;
    int s;
    exp_t e;
    @(negedge clk);
    vld = v; d0 = a; d1 = b; clear_i = clr; step_i = stp;
    #1;
    chk("acc", o_acc, m_acc);
    chk("overflow", o_ovf, m_ovf);
    chk("op_count", o_cnt, m_cnt);
    chk("last_src", o_src, m_lsrc);
    chk("busy", o_busy, m_hold);
    exp_rdy = 2'b00;
    g = -1;
    if (m_hold == 0 && !clr && v != 2'b00) begin
      if (v == 2'b11) g = (m_last == 0) ? 1 : 0;
      else g = v[1] ? 1 : 0;
      exp_rdy[g] = 1'b1;
    end
    chk("req_ready", o_rdy, exp_rdy);
    if (clr) begin
      m_acc = 0; m_ovf = 0; m_cnt = 0; m_hold = 0;
    end else if (m_hold != 0) begin
      if (sel == 0 || stp) begin
        s = m_acc + m_op;
        if (s > 255) m_ovf = 1;
        m_acc = s % 256;
        if (m_cnt < 15) m_cnt++;
        m_lsrc = m_src;
        m_hold = 0;
        e.acc = m_acc; e.ovf = m_ovf; e.cnt = m_cnt; e.src = m_lsrc; e.at = cyc + 1;
        sb.push_back(e);
      end
    end else if (g >= 0) begin
      m_hold = 1;
      m_op = (g == 1) ? int'(b) : int'(a);
      m_src = g;
      m_last = g;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    sel = 0; vld = 2'b00; d0 = 8'h00; d1 = 8'h00; clear_i = 1'b0; step_i = 1'b0;
    resetn = 1'b0;
    model_reset();
    #12;
    chk("rst_acc0", acc0, 8'h00);
    chk("rst_cnt0", cnt0, 4'h0);
    chk("rst_busy_done0", {ovf0, src0, busy0, done0}, 4'b0000);
    chk("rst_acc1", acc1, 8'h00);
    chk("rst_busy_done1", {ovf1, src1, busy1, done1, cnt1}, 8'h00);
    @(negedge clk);
    resetn = 1'b1;

    // Single operand from requester 0.
    step_cycle(2'b01, 8'h05, 8'h00, 1'b0, 1'b0);
    idle(2);
    chk("t1_acc", o_acc, 8'h05);
    chk("t1_cnt", o_cnt, 4'h1);

    // Contention held for four operations.
    step_cycle(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step_cycle(2'b11, 8'h01, 8'h02, 1'b0, 1'b0);
    idle(1);
    chk("t2_acc", o_acc, 8'h06);
    chk("t2_cnt", o_cnt, 4'h4);

    // Carry-out wraps and stays sticky.
    step_cycle(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
    step_cycle(2'b01, 8'hF0, 8'h00, 1'b0, 1'b0);
    step_cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    step_cycle(2'b10, 8'h00, 8'h20, 1'b0, 1'b0);
    step_cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    idle(1);
    chk("t3_acc", o_acc, 8'h10);
    chk("t3_ovf", o_ovf, 1'b1);
    step_cycle(2'b01, 8'h01, 8'h00, 1'b0, 1'b0);
    idle(2);
    chk("t3_acc2", o_acc, 8'h11);
    chk("t3_ovf2", o_ovf, 1'b1);

    // Random traffic, unpaced.
    for (int i = 0; i < 300; i++)
      step_cycle(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    idle(3);

    // Switch to the paced instance, which has seen nothing since reset.
    sel = 1;
    model_reset();
    step_cycle(2'b01, 8'h03, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step_cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("t4_busy", o_busy, 1'b1);
    chk("t4_acc_held", o_acc, 8'h00);
    step_cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    idle(1);
    chk("t4_acc", o_acc, 8'h03);

    // Clear and step together while holding: clear wins, no commit.
    step_cycle(2'b10, 8'h00, 8'h09, 1'b0, 1'b0);
    step_cycle(2'b00, 8'h00, 8'h00, 1'b1, 1'b1);
    idle(1);
    chk("t5_acc", o_acc, 8'h00);
    chk("t5_cnt_busy", {o_cnt, o_busy}, 5'h00);

    // Counter saturation.
    for (int i = 0; i < 20; i++) begin
      step_cycle(2'b01, 8'h00, 8'h00, 1'b0, 1'b0);
      step_cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    end
    idle(1);
    chk("t6_cnt_sat", o_cnt, 4'hF);

    // Random traffic, paced.
    for (int i = 0; i < 300; i++)
      step_cycle(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0));
    step_cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    idle(2);

    // Asynchronous reset while an operand is held.
    step_cycle(2'b01, 8'h07, 8'h00, 1'b0, 1'b0);
    step_cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    vld = 2'b00; clear_i = 1'b0; step_i = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("rstmid_acc", o_acc, 8'h00);
    chk("rstmid_cnt", o_cnt, 4'h0);
    chk("rstmid_flags", {o_ovf, o_src, o_busy, o_done}, 4'b0000);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    step_cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    step_cycle(2'b11, 8'h04, 8'h08, 1'b0, 1'b0);
    step_cycle(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
    idle(2);
    chk("post_rst_acc", o_acc, 8'h04);

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
